// File: rtl/tmds_pkg.sv
// Shared TMDS types and constants: control symbols, disparity width, popcount helper.
// Pure declarations, no timing or flow control.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam int TMDS_CNT_W = 5;

  localparam tmds_sym_t TMDS_CTRL_00 = 10'h354;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'h0AB;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'h154;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_rgb_encoder_if.sv
// Pixel-side bus (de, syncs, RGB) and symbol outputs of the RGB TMDS encoder.
// No handshake: every field is valid on every clock.
interface tmds_rgb_encoder_if;
  import tmds_pkg::*;

  logic      de;
  logic      hsync_in;
  logic      vsync_in;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  tmds_sym_t r;
  tmds_sym_t g;
  tmds_sym_t b;

  modport master (
    output de, hsync_in, vsync_in, r_in, g_in, b_in,
    input  r, g, b
  );

  modport slave (
    input  de, hsync_in, vsync_in, r_in, g_in, b_in,
    output r, g, b
  );

endinterface

// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS 8b/10b encoder with running disparity; 2-cycle latency.
// No backpressure: one symbol per clock, control symbols clear the disparity.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      de,
  input  logic      c0,
  input  logic      c1,
  input  logic [7:0] d,
  output tmds_sym_t q
);

  logic [7:0] d_s1;
  logic [3:0] n1d_s1;
  logic       de_s1;
  logic [1:0] ctl_s1;

  logic signed [TMDS_CNT_W-1:0] cnt;
  logic signed [TMDS_CNT_W-1:0] cnt_nxt;
  logic signed [TMDS_CNT_W-1:0] diff;
  logic signed [TMDS_CNT_W-1:0] two_qm8;
  tmds_sym_t  q_nxt;
  logic       use_xnor;
  logic [8:0] qm;
  logic [3:0] n1q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_s1   <= '0;
      n1d_s1 <= '0;
      de_s1  <= 1'b0;
      ctl_s1 <= 2'b00;
    end else begin
      d_s1   <= d;
      n1d_s1 <= popcount8(d);
      de_s1  <= de;
      ctl_s1 <= {c1, c0};
    end
  end

  always_comb begin
    use_xnor = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !d_s1[0]);
    qm       = '0;
    qm[0]    = d_s1[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d_s1[i]) : (qm[i-1] ^ d_s1[i]);
    end
    qm[8]   = ~use_xnor;
    n1q     = popcount8(qm[7:0]);
    // n1 - n0 == 2*n1 - 8; modulo-32 wrap of the 5-bit result is harmless
    diff    = $signed({n1q, 1'b0} - 5'd8);
    two_qm8 = qm[8] ? 5'sd2 : 5'sd0;

    q_nxt   = TMDS_CTRL_00;
    cnt_nxt = cnt;
    if (!de_s1) begin
      cnt_nxt = 5'sd0;
      case (ctl_s1)
        2'b00:   q_nxt = TMDS_CTRL_00;
        2'b01:   q_nxt = TMDS_CTRL_01;
        2'b10:   q_nxt = TMDS_CTRL_10;
        default: q_nxt = TMDS_CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      q_nxt   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_nxt = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      q_nxt   = {1'b1, qm[8], ~qm[7:0]};
      cnt_nxt = cnt + two_qm8 - diff;
    end else begin
      q_nxt   = {1'b0, qm[8], qm[7:0]};
      cnt_nxt = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= TMDS_CTRL_00;
      cnt <= '0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/tmds_rgb_encoder.sv
// Three-channel DVI/TMDS encoder: sync polarity correction and channel mapping; 2-cycle latency.
// No backpressure: one symbol per channel every clock.
module tmds_rgb_encoder #(
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  tmds_rgb_encoder_if.slave  px
);

  logic hsync_act;
  logic vsync_act;

  // Normalise so that 1 always means "sync active" on the blue channel.
  assign hsync_act = px.hsync_in ^ ~HSYNC_POL;
  assign vsync_act = px.vsync_in ^ ~VSYNC_POL;

  tmds_channel_encoder u_b (
    .clk   (clk),
    .reset (reset),
    .de    (px.de),
    .c0    (hsync_act),
    .c1    (vsync_act),
    .d     (px.b_in),
    .q     (px.b)
  );

  tmds_channel_encoder u_g (
    .clk   (clk),
    .reset (reset),
    .de    (px.de),
    .c0    (1'b0),
    .c1    (1'b0),
    .d     (px.g_in),
    .q     (px.g)
  );

  tmds_channel_encoder u_r (
    .clk   (clk),
    .reset (reset),
    .de    (px.de),
    .c0    (1'b0),
    .c1    (1'b0),
    .d     (px.r_in),
    .q     (px.r)
  );

endmodule

// File: tb/tb_tmds_rgb_encoder.sv
// Directed and random-line bench for tmds_rgb_encoder: control mapping, disparity,
// pipeline alignment, async reset, decode and DC balance.
module tb_tmds_rgb_encoder;
  import tmds_pkg::*;

  localparam int LINE_LEN = 256;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  tmds_sym_t  prev_b;
  tmds_sym_t  ctrl_exp [4];
  logic [7:0] hist_r [LINE_LEN];
  logic [7:0] hist_g [LINE_LEN];
  logic [7:0] hist_b [LINE_LEN];
  int         disp_r, disp_g, disp_b;

  tmds_rgb_encoder_if bus ();

  tmds_rgb_encoder #(
    .HSYNC_POL (1'b1),
    .VSYNC_POL (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .px    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] m;
    logic [7:0] d;
    m    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = m[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    end
    return d;
  endfunction

  initial begin
    ctrl_exp[0] = TMDS_CTRL_00;
    ctrl_exp[1] = TMDS_CTRL_01;
    ctrl_exp[2] = TMDS_CTRL_10;
    ctrl_exp[3] = TMDS_CTRL_11;

    reset        = 1'b1;
    bus.de       = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    bus.r_in     = 8'h00;
    bus.g_in     = 8'h00;
    bus.b_in     = 8'h00;
    tick();
    tick();
    chk("reset_r", bus.r, 10'h354);
    chk("reset_g", bus.g, 10'h354);
    chk("reset_b", bus.b, 10'h354);
    chk("reset_cnt_b", dut.u_b.cnt, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_b1", bus.b, 10'h354);
    tick();
    chk("post_reset_b2", bus.b, 10'h354);
    chk("post_reset_r2", bus.r, 10'h354);
    chk("post_reset_g2", bus.g, 10'h354);

    // Control period: {vsync, hsync} stepping through all four codes
    for (int k = 0; k < 4; k++) begin
      prev_b       = bus.b;
      bus.vsync_in = k[1];
      bus.hsync_in = k[0];
      tick();
      chk("ctrl_latency1", bus.b, prev_b);
      tick();
      chk("ctrl_b", bus.b, ctrl_exp[k]);
      chk("ctrl_r", bus.r, 10'h354);
      chk("ctrl_g", bus.g, 10'h354);
    end
    bus.vsync_in = 1'b0;
    bus.hsync_in = 1'b0;
    tick();
    tick();
    chk("ctrl_back_b", bus.b, 10'h354);

    // Three zero pixels on blue from cnt = 0
    bus.de = 1'b1;
    tick();
    tick();
    chk("disp0_b", bus.b, 10'h100);
    chk("disp0_cnt", dut.u_b.cnt, -8);
    tick();
    chk("disp1_b", bus.b, 10'h3FF);
    chk("disp1_cnt", dut.u_b.cnt, 2);
    bus.de = 1'b0;
    tick();
    chk("disp2_b", bus.b, 10'h100);
    chk("disp2_cnt", dut.u_b.cnt, -6);
    tick();
    chk("disp_end_b", bus.b, 10'h354);
    chk("disp_end_cnt", dut.u_b.cnt, 0);

    // One-cycle pixel: XNOR path on green, alignment on blue/red
    bus.de   = 1'b1;
    bus.g_in = 8'hFF;
    bus.b_in = 8'h00;
    bus.r_in = 8'h00;
    tick();
    chk("align_pre_b", bus.b, 10'h354);
    bus.de   = 1'b0;
    bus.g_in = 8'h00;
    tick();
    chk("align_b", bus.b, 10'h100);
    chk("align_r", bus.r, 10'h100);
    chk("xnor_g", bus.g, 10'h200);
    chk("xnor_cnt_g", dut.u_g.cnt, -8);
    chk("align_cnt_b", dut.u_b.cnt, -8);
    tick();
    chk("align_post_b", bus.b, 10'h354);
    chk("align_post_g", bus.g, 10'h354);
    chk("align_post_cnt_b", dut.u_b.cnt, 0);
    chk("align_post_cnt_g", dut.u_g.cnt, 0);

    // Asynchronous reset in the middle of active video
    bus.de   = 1'b1;
    bus.g_in = 8'hFF;
    tick();
    tick();
    chk("midrst_pre_b", bus.b, 10'h100);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_b", bus.b, 10'h354);
    chk("midrst_g", bus.g, 10'h354);
    chk("midrst_r", bus.r, 10'h354);
    chk("midrst_cnt_b", dut.u_b.cnt, 0);
    chk("midrst_cnt_g", dut.u_g.cnt, 0);
    bus.de   = 1'b0;
    bus.g_in = 8'h00;
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Random active line: decode every byte and track running DC balance
    disp_r = 0;
    disp_g = 0;
    disp_b = 0;
    for (int k = 0; k < LINE_LEN + 2; k++) begin
      if (k >= 2) begin
        chk("rand_dec_r", tmds_dec(bus.r), hist_r[k-2]);
        chk("rand_dec_g", tmds_dec(bus.g), hist_g[k-2]);
        chk("rand_dec_b", tmds_dec(bus.b), hist_b[k-2]);
        disp_r += 2 * $countones(bus.r) - 10;
        disp_g += 2 * $countones(bus.g) - 10;
        disp_b += 2 * $countones(bus.b) - 10;
        chk("rand_cnt_r", dut.u_r.cnt, disp_r);
        chk("rand_cnt_g", dut.u_g.cnt, disp_g);
        chk("rand_cnt_b", dut.u_b.cnt, disp_b);
        chk("rand_dc_bound",
            ((disp_r <= 10) && (disp_r >= -10) && (disp_g <= 10) && (disp_g >= -10) &&
             (disp_b <= 10) && (disp_b >= -10)) ? 1 : 0, 1);
        chk("rand_cnt_even", {dut.u_r.cnt[0], dut.u_g.cnt[0], dut.u_b.cnt[0]}, 0);
      end
      if (k < LINE_LEN) begin
        hist_r[k] = 8'($urandom_range(255));
        hist_g[k] = 8'($urandom_range(255));
        hist_b[k] = 8'($urandom_range(255));
        bus.de    = 1'b1;
        bus.r_in  = hist_r[k];
        bus.g_in  = hist_g[k];
        bus.b_in  = hist_b[k];
      end else begin
        bus.de = 1'b0;
      end
      tick();
    end
    chk("line_end_b", bus.b, 10'h354);
    chk("line_end_cnt_b", dut.u_b.cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmds_rgb_encoder.md
# tmds_rgb_encoder

Three-channel DVI/TMDS 8b/10b encoder that converts 24-bit RGB pixels plus sync and data-enable into three 10-bit TMDS symbols. Sits directly upstream of the GTH serializer and drives its 10-bit `r`, `g`, `b` symbol inputs. It runs in the pixel/symbol clock domain. Each channel keeps its own running disparity and uses a fixed two-cycle pipeline.

## Interface
- `HSYNC_POL`, default 1'b1: active level of `hsync_in`. The input is XORed with ~HSYNC_POL before encoding, so the encoded value is 1 when hsync is active.
- `VSYNC_POL`, default 1'b1: same rule, applied to `vsync_in`.

- `clk`  in  1  pixel/symbol clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `de`  in  1  data enable: 1 = active video, 0 = control period.
- `hsync_in`  in  1  horizontal sync.
- `vsync_in`  in  1  vertical sync.
- `r_in`  in  8  red pixel.
- `g_in`  in  8  green pixel.
- `b_in`  in  8  blue pixel.
- `r`  out  10  red-channel TMDS symbol (channel 2). Bit 0 is transmitted first.
- `g`  out  10  green-channel TMDS symbol (channel 1).
- `b`  out  10  blue-channel TMDS symbol (channel 0).

## Operation
- Each channel is an independent encoder.
  - Blue: control bits c0 = hsync, c1 = vsync.
  - Green and red: c0 = c1 = 0.
- Stage 1 (registered): compute N1(d), the popcount of the 8-bit input (4 bits wide). Register d, N1, de, c1c0.
- Stage 2 (registered output), combinational part, transition minimisation:
  - Use XNOR if N1(d) > 4, or if N1(d) == 4 and d[0] == 0. Otherwise use XOR.
  - qm[0] = d[0]; qm[i] = qm[i-1] op d[i].
  - qm[8] = 1 for XOR, 0 for XNOR.
- Disparity counter `cnt`: 5-bit signed, per channel. It is always even and stays within -10..+10.
- Let n1 = N1(qm[7:0]) and n0 = 8 - n1.
- When de = 1, the first matching rule applies:
  - If cnt == 0 or n1 == n0:
    - out = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]}.
    - cnt += qm[8] ? (n1 - n0) : (n0 - n1).
  - If (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - out = {1, qm[8], ~qm[7:0]}.
    - cnt += 2*qm[8] + (n0 - n1).
  - Otherwise:
    - out = {0, qm[8], qm[7:0]}.
    - cnt += (n1 - n0) - 2*~qm[8].
- When de = 0, the symbol comes from c1c0 and cnt is cleared to 0:
  - 00 → 10'h354
  - 01 → 10'h0AB
  - 10 → 10'h154
  - 11 → 10'h2AB
- No handshake. One symbol is produced every clock, unconditionally.

## Timing
- Latency is exactly 2 cycles from the input sample edge to the output change. This holds for pixel data and control alike.
- de, hsync and vsync are pipelined alongside the data, so symbol type and payload always stay aligned.
- Reset values:
  - `r`, `g` = 10'h354.
  - `b` = 10'h354 (c1c0 = 00).
  - All cnt = 0.
  - Stage-1 registers hold de = 0, c1c0 = 00.
  - Outputs therefore show control symbol 10'h354 for the 2 cycles after reset release.
- Reset asserted mid-line: all outputs go to 10'h354 and cnt = 0 immediately, without waiting for a clock edge.
- On a de 1→0 transition, the first control symbol appears 2 cycles later and cnt clears on that same edge.
- On a de 0→1 transition, the first data symbol is encoded from cnt = 0.
- Wrap-around: cnt never saturates and never wraps in legal operation. The bench asserts |cnt| ≤ 10.

## Structure
- Shared package `tmds_pkg`:
  - The four control-symbol constants (`TMDS_CTRL_00` .. `TMDS_CTRL_11`).
  - The cnt width constant (5).
  - A `tmds_sym_t` typedef, `logic [9:0]`.
- One sub-module, `tmds_channel_encoder`: ports clk, reset, de, c0, c1, d[7:0], q[9:0]. It is instantiated three times.
- The top level does only sync polarity correction and channel mapping.

## Test plan
- Reset: hold reset, then release with de = 0, hsync = vsync = 0 → `r`, `g`, `b` = 10'h354. Asserting reset mid-stream returns the outputs to 10'h354 asynchronously.
- Control mapping: de = 0 with {vsync, hsync} stepping through 00/01/10/11 → `b` = 354/0AB/154/2AB, each appearing 2 cycles after input; `r` and `g` stay at 354.
- Disparity sequence: de = 1, b_in = 8'h00 for three cycles starting from cnt = 0 → `b` = 10'h100, 10'h3FF, 10'h100; cnt = -8, +2, -6.
- XNOR path: de = 1, g_in = 8'hFF from cnt = 0 → `g` = 10'h200, cnt = -8.
- Pipeline alignment: de 0→1→0 with a one-cycle pixel b_in = 8'h00 → exactly one data symbol, 10'h100, bracketed by control symbols at 2-cycle latency; cnt returns to 0.
- Randomised pixels over a long active line:
  - A reference decoder recovers every input byte.
  - The running DC balance over the line stays within ±10.
  - cnt is always even.
